// File: rtl/mux16_rr_arbiter_pkg.sv
// Shared constants and state encoding for the 16-way round-robin arbiter.
// Also provides a one-hot decode helper used by the top level.
package mux16_rr_arbiter_pkg;
  localparam int NUM_REQ = 16;
  localparam int SEL_W   = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } state_t;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction
endpackage

// File: rtl/mux16_rr_arbiter_mux.sv
// 16:1 word multiplexer; requester i occupies bits [i*size +: size].
module mux_16to1 #(
  parameter int size = 4
) (
  input  logic [16*size-1:0] in_data,
  input  logic [3:0]         sel,
  output logic [size-1:0]    out_data
);
  assign out_data = in_data[sel*size +: size];
endmodule

// File: rtl/mux16_rr_arbiter_pick.sv
// Combinational round-robin picker: first set request bit at or after ptr,
// wrapping modulo 16.
module rr_pick16
  import mux16_rr_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               any,
  output logic [SEL_W-1:0]   idx
);
  logic [2*NUM_REQ-1:0] w_dbl;
  logic [NUM_REQ-1:0]   w_rot;
  logic [SEL_W-1:0]     w_off;

  // Rotating right by ptr puts requester ptr at bit 0, so a plain
  // lowest-bit priority encode yields the offset from ptr.
  assign w_dbl = {req, req} >> ptr;
  assign w_rot = w_dbl[NUM_REQ-1:0];

  // NOTE: default first so no path through the loop leaves w_off unassigned (no latch).
  always_comb begin
    w_off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = SEL_W'(i);
    end
  end

  assign any = |req;
  assign idx = w_off + ptr;
endmodule

// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter sharing one 16:1 mux among 16 requesters, presenting
// the granted word on a valid/ready port with back-to-back single-beat transfers.
module mux16_rr_arbiter
  import mux16_rr_arbiter_pkg::*;
#(
  parameter int size = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ*size-1:0] in_data,
  output logic [NUM_REQ-1:0]      grant,
  output logic [SEL_W-1:0]        sel,
  output logic [size-1:0]         out_data,
  output logic                    out_valid,
  input  logic                    out_ready
);
  state_t             r_state;
  logic [NUM_REQ-1:0] r_grant;
  logic [SEL_W-1:0]   r_sel;
  logic [SEL_W-1:0]   r_ptr;
  logic               r_valid;

  logic               w_xfer;
  logic [NUM_REQ-1:0] w_req;
  logic [SEL_W-1:0]   w_ptr;
  logic               w_any;
  logic [SEL_W-1:0]   w_idx;

  // On a transfer edge the served requester is masked and the search starts
  // just past it, so the re-arbitration lands on the next requester in turn.
  assign w_xfer = r_valid && out_ready;
  assign w_req  = w_xfer ? (req & ~onehot(r_sel)) : req;
  assign w_ptr  = w_xfer ? r_sel + 1'b1 : r_ptr;

  rr_pick16 u_pick (
    .req (w_req),
    .ptr (w_ptr),
    .any (w_any),
    .idx (w_idx)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_sel   <= '0;
      r_ptr   <= '0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (en && w_any) begin
            r_state <= ST_OFFER;
            r_valid <= 1'b1;
            r_sel   <= w_idx;
            r_grant <= onehot(w_idx);
          end
        end
        ST_OFFER: begin
          if (out_ready) begin
            r_ptr <= w_ptr;
            if (en && w_any) begin
              r_sel   <= w_idx;
              r_grant <= onehot(w_idx);
            end else begin
              r_state <= ST_IDLE;
              r_valid <= 1'b0;
              r_grant <= '0;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign grant     = r_grant;
  assign sel       = r_sel;
  assign out_valid = r_valid;

  mux_16to1 #(.size(size)) u_mux (
    .in_data  (in_data),
    .sel      (r_sel),
    .out_data (out_data)
  );
endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Self-checking bench for mux16_rr_arbiter: directed scenarios plus a
// randomized run, all compared against a behavioural round-robin model.
module tb_mux16_rr_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] req;
  logic [63:0] in_data;
  logic [15:0] grant;
  logic [3:0]  sel;
  logic [3:0]  out_data;
  logic        out_valid;
  logic        out_ready;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: whether a word is offered, who is offered, and where the
  // next search starts.
  bit m_valid;
  int m_sel;
  int m_ptr;

  mux16_rr_arbiter #(.size(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req       (req),
    .in_data   (in_data),
    .grant     (grant),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  function automatic int scan(input logic [15:0] r, input int p);
    for (int k = 0; k < 16; k++) begin
      if (r[(p + k) % 16]) return (p + k) % 16;
    end
    return -1;
  endfunction

  function automatic logic [15:0] exp_grant();
    return m_valid ? (16'h1 << m_sel) : 16'h0;
  endfunction

  function automatic logic [3:0] exp_data();
    logic [63:0] sh;
    sh = in_data >> (m_sel * 4);
    return sh[3:0];
  endfunction

  // Advance one clock, updating the model from the inputs the DUT samples.
  task automatic step();
    bit          nv;
    int          ns, np, w;
    logic [15:0] mr;
    nv = m_valid; ns = m_sel; np = m_ptr;
    if (rst) begin
      nv = 0; ns = 0; np = 0;
    end else if (!m_valid) begin
      w = scan(req, m_ptr);
      if (en && w >= 0) begin nv = 1; ns = w; end
    end else if (out_ready) begin
      np = (m_sel + 1) % 16;
      mr = req & ~(16'h1 << m_sel);
      w  = scan(mr, np);
      if (en && w >= 0) ns = w;
      else nv = 0;
    end
    @(posedge clk);
    #1;
    m_valid = nv; m_sel = ns; m_ptr = np;
  endtask

  task automatic test_reset();
    rst = 1; en = 1; req = 16'hFFFF; out_ready = 0;
    in_data = {$urandom, $urandom};
    for (int c = 0; c < 2; c++) begin
      step();
      n_checks++;
      if (grant !== 16'h0 || out_valid !== 1'b0 || sel !== 4'd0) begin
        n_errors++;
        $display("FAIL reset_during: grant=%h valid=%b sel=%0d, want 0000/0/0", grant, out_valid, sel);
      end
    end
    rst = 0;
    #1;
    n_checks++;
    if (grant !== 16'h0 || out_valid !== 1'b0 || sel !== 4'd0) begin
      n_errors++;
      $display("FAIL reset_release: grant=%h valid=%b sel=%0d, want 0000/0/0", grant, out_valid, sel);
    end
    step();
    n_checks++;
    if (grant !== 16'h0001 || out_valid !== 1'b1 || sel !== 4'd0) begin
      n_errors++;
      $display("FAIL reset_first_grant: grant=%h valid=%b sel=%0d, want 0001/1/0", grant, out_valid, sel);
    end
    req = 16'h0; out_ready = 1;
    step();
    n_checks++;
    if (out_valid !== 1'b0 || grant !== 16'h0) begin
      n_errors++;
      $display("FAIL reset_drain: grant=%h valid=%b, want 0000/0", grant, out_valid);
    end
  endtask

  task automatic test_single();
    in_data = {$urandom, $urandom};
    in_data[23:20] = 4'hA;
    req = 16'h0020; out_ready = 1; en = 1;
    step();
    n_checks++;
    if (out_valid !== 1'b1 || sel !== 4'd5 || grant !== 16'h0020 || out_data !== 4'hA) begin
      n_errors++;
      $display("FAIL single_grant: valid=%b sel=%0d grant=%h data=%h, want 1/5/0020/a",
               out_valid, sel, grant, out_data);
    end
    req = 16'h0;
    step();
    n_checks++;
    if (out_valid !== 1'b0 || grant !== 16'h0 || sel !== 4'd5) begin
      n_errors++;
      $display("FAIL single_idle: valid=%b grant=%h sel=%0d, want 0/0000/5", out_valid, grant, sel);
    end
  endtask

  task automatic test_wrap();
    logic [3:0] want;
    rst = 1; step(); rst = 0;
    req = 16'h8001; out_ready = 1; en = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      want = (i % 2 == 0) ? 4'd0 : 4'd15;
      n_checks++;
      if (out_valid !== 1'b1 || sel !== want || grant !== (16'h1 << want)) begin
        n_errors++;
        $display("FAIL wrap_%0d: valid=%b sel=%0d grant=%h, want 1/%0d/%h",
                 i, out_valid, sel, grant, want, 16'h1 << want);
      end
    end
    req = 16'h0;
    step();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL wrap_idle: valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    req = 16'h0008; out_ready = 0; en = 1;
    step();
    n_checks++;
    if (sel !== 4'd3 || grant !== 16'h0008 || out_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL bp_grant: sel=%0d grant=%h valid=%b, want 3/0008/1", sel, grant, out_valid);
    end
    req = 16'h0100;
    for (int c = 0; c < 5; c++) begin
      step();
      n_checks++;
      if (sel !== 4'd3 || grant !== 16'h0008 || out_valid !== 1'b1) begin
        n_errors++;
        $display("FAIL bp_hold_%0d: sel=%0d grant=%h valid=%b, want 3/0008/1", c, sel, grant, out_valid);
      end
    end
    out_ready = 1;
    step();
    n_checks++;
    if (sel !== 4'd8 || grant !== 16'h0100 || out_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL bp_next: sel=%0d grant=%h valid=%b, want 8/0100/1", sel, grant, out_valid);
    end
    req = 16'h0;
    step();
  endtask

  task automatic test_enable();
    en = 0; req = 16'h0010; out_ready = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      n_checks++;
      if (out_valid !== 1'b0 || grant !== 16'h0) begin
        n_errors++;
        $display("FAIL en_block_%0d: valid=%b grant=%h, want 0/0000", c, out_valid, grant);
      end
    end
    en = 1;
    step();
    n_checks++;
    if (out_valid !== 1'b1 || sel !== 4'd4 || grant !== 16'h0010) begin
      n_errors++;
      $display("FAIL en_grant: valid=%b sel=%0d grant=%h, want 1/4/0010", out_valid, sel, grant);
    end
    en = 0;
    step();
    n_checks++;
    if (out_valid !== 1'b1 || grant !== 16'h0010) begin
      n_errors++;
      $display("FAIL en_hold: valid=%b grant=%h, want 1/0010", out_valid, grant);
    end
    out_ready = 1;
    for (int c = 0; c < 2; c++) begin
      step();
      n_checks++;
      if (out_valid !== 1'b0 || grant !== 16'h0) begin
        n_errors++;
        $display("FAIL en_idle_%0d: valid=%b grant=%h, want 0/0000", c, out_valid, grant);
      end
    end
    en = 1; req = 16'h0;
  endtask

  task automatic test_reset_mid();
    req = 16'h0200; out_ready = 0; en = 1;
    step();
    n_checks++;
    if (sel !== 4'd9 || out_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL rmid_grant: sel=%0d valid=%b, want 9/1", sel, out_valid);
    end
    rst = 1;
    step();
    n_checks++;
    if (out_valid !== 1'b0 || grant !== 16'h0 || sel !== 4'd0) begin
      n_errors++;
      $display("FAIL rmid_reset: valid=%b grant=%h sel=%0d, want 0/0000/0", out_valid, grant, sel);
    end
    rst = 0; req = 16'hFFFF;
    step();
    n_checks++;
    if (sel !== 4'd0 || grant !== 16'h0001 || out_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL rmid_restart: sel=%0d grant=%h valid=%b, want 0/0001/1", sel, grant, out_valid);
    end
    req = 16'h0; out_ready = 1;
    step();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst       = ($urandom_range(0, 59) == 0);
      en        = ($urandom_range(0, 7) != 0);
      out_ready = $urandom_range(0, 1);
      case ($urandom_range(0, 3))
        0:       req = 16'h0;
        1:       req = 16'h1 << $urandom_range(0, 15);
        2:       req = 16'hFFFF;
        default: req = 16'($urandom);
      endcase
      in_data = {$urandom, $urandom};
      step();
      n_checks++;
      if (out_valid !== m_valid || grant !== exp_grant() || sel !== 4'(m_sel)) begin
        n_errors++;
        $display("FAIL rand_%0d: valid=%b grant=%h sel=%0d, want %b/%h/%0d",
                 c, out_valid, grant, sel, m_valid, exp_grant(), m_sel);
      end
      n_checks++;
      if (out_data !== exp_data()) begin
        n_errors++;
        $display("FAIL rand_data_%0d: data=%h, want %h", c, out_data, exp_data());
      end
    end
    rst = 0;
  endtask

  initial begin
    m_valid = 0; m_sel = 0; m_ptr = 0;
    test_reset();
    test_single();
    test_wrap();
    test_backpressure();
    test_enable();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/mux16_rr_arbiter.md
Name: mux16_rr_arbiter

Overview:
- Round-robin arbiter and scheduler that shares one 16:1 data mux (mux_16to1) between 16 requesters.
- Accepts per-requester request lines and drives the mux select and a one-hot grant.
- Presents the selected word on a valid/ready output port.
- Sits between 16 producers and a single downstream consumer; one single-beat transfer per grant.

Parameters:
- size, 4, data width of each requester word and of out_data (passed to mux_16to1).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  arbitration enable; low blocks new grants, does not abort a grant in progress.
- req  input  16  per-requester request; bit i high = requester i has a word on in_data slice i.
- in_data  input  16*size  packed requester words; requester i occupies bits [i*size +: size].
- grant  output  16  one-hot grant, registered; all-zero when idle.
- sel  output  4  registered index of granted requester; drives mux_16to1 sel.
- out_data  output  size  word of granted requester (mux output, combinational from sel and in_data).
- out_valid  output  1  registered; high while a granted word is offered.
- out_ready  input  1  consumer accepts out_data when out_valid && out_ready (transfer).

Behaviour:
- Reset (rst=1 at clk edge) forces the following, regardless of state; a transfer in flight is aborted with no handshake:
  - state=IDLE, grant=16'h0000, sel=4'd0, out_valid=0, priority pointer ptr=4'd0.
- Two states, IDLE and OFFER.
- IDLE:
  - If en=1 and req!=0, pick the winner, then next cycle: state=OFFER, out_valid=1, sel=winner, grant=1<<winner.
  - Otherwise remain IDLE.
  - Latency from req seen to out_valid is 1 cycle.
- Winner: first set bit of req scanning ptr, ptr+1, ..., 15, 0, ..., ptr-1 (mod-16 wrap).
- OFFER, out_valid=1 && out_ready=0:
  - sel, grant and out_valid hold stable; no re-arbitration.
  - Changes on req or en are ignored.
- OFFER, out_valid=1 && out_ready=1 (transfer):
  - ptr <= sel+1, mod 16, so 15 wraps to 0.
  - Same edge, if en=1 and (req with bit sel cleared)!=0: re-arbitrate from the new ptr, stay in OFFER, load the new sel/grant. Back-to-back transfers run at 1 per cycle.
  - Otherwise go to IDLE with grant=0, out_valid=0; sel keeps its last value.
- The just-served requester's req bit is masked for the transfer edge only. Requester i deasserts req the cycle after it sees grant[i] && out_ready.
- A requester dropping req while granted does not retract the grant; its word is still offered until accepted.
- Fairness: with all 16 requesting continuously, grants cycle 0,1,...,15,0; no requester waits more than 15 transfers.
- ptr advances only on a transfer, never on en or req changes.
- out_data = in_data[sel*size +: size] via mux_16to1; in_data must be stable while out_valid && !out_ready.
- Invariants:
  - grant == (out_valid ? 1<<sel : 0).
  - At most one grant bit set.
  - sel is never X after reset.

Decomposition:
- Shared package/header: state encodings ST_IDLE=1'b0, ST_OFFER=1'b1; constant NUM_REQ=16; SEL_W=4.
- Sub-module rr_pick16: combinational; inputs req[15:0], ptr[3:0]; outputs any (1), idx[3:0].
  - Implementation: rotate req right by ptr, priority-encode, add ptr mod 16.
- Data path instantiates mux_16to1 with size passed through.

Test Plan:
- Reset: assert rst for 2 cycles with req=16'hFFFF -> grant=0, out_valid=0, sel=0 during and 1 cycle after release. First grant then goes to requester 0.
- Single request: req=16'h0020, in_data slice5=4'hA, out_ready=1 -> next cycle out_valid=1, sel=5, grant=16'h0020, out_data=4'hA. After the transfer, with req=0, return to IDLE.
- Round-robin wrap: req=16'h8001 held, out_ready=1 -> grant sequence 0,15,0,15, back-to-back with out_valid continuously 1. ptr wraps from 15 to 0.
- Backpressure: grant sel=3, out_ready=0 for 5 cycles while req changes to 16'h0100 -> sel=3, grant=16'h0008 stable. On out_ready=1 the next grant is 8.
- Enable gating: en=0, req=16'h0010 -> no grant. Deassert en during OFFER with out_ready=0 -> current grant completes on out_ready, then IDLE.
- Reset mid-transfer: rst=1 while out_valid=1, sel=9 -> next cycle out_valid=0, grant=0, ptr=0. Arbitration restarts from requester 0.
